ekf_stage_ctrl: RTL and testbench

- Top-level stage controller of the EKF-SLAM accelerator.
- Accepts a stage command (predict, new-landmark, update, association) plus robot/landmark operands, and latches the operands.
- Sequences the stage for a deterministic, size-dependent number of cycles, then reports completion on stage_rdy.
- Systolic-array datapath and memories sit behind this block and are outside this spec.

---
 rtl/ekf_pkg.sv | 50 +++++
 rtl/ekf_stage_seq.sv | 68 ++++++
 rtl/ekf_stage_ctrl.sv | 67 ++++++
 tb/tb_ekf_stage_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ekf_pkg.sv
// Shared definitions for the EKF-SLAM stage controller: stage codes, fixed-point
// constants, sequencer state encoding and the per-stage latency formula.
package ekf_pkg;

    localparam logic [2:0] STAGE_IDLE  = 3'b000;
    localparam logic [2:0] STAGE_PRD   = 3'b001;
    localparam logic [2:0] STAGE_NEW   = 3'b010;
    localparam logic [2:0] STAGE_UPD   = 3'b011;
    localparam logic [2:0] STAGE_ASSOC = 3'b100;

    localparam int DATA_INT_BIT  = 12;
    localparam int DATA_DEC_BIT  = 19;
    localparam int ANGLE_DEC_BIT = 15;

    // Array geometry and buffer widths consumed by the datapath behind this block
    localparam int SA_COLS    = 4;
    localparam int SA_DEPTH   = 4;
    localparam int TB_AW      = 11;
    localparam int CB_AW      = 17;
    localparam int SEQ_CNT_DW = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } seq_state_e;

    function automatic logic is_stage_cmd(input logic [2:0] code);
        return (code != STAGE_IDLE) && (code <= STAGE_ASSOC);
    endfunction

    // Edges from the accepting edge to the edge that raises stage_rdy.
    function automatic logic [31:0] stage_latency(input logic [2:0]  stage,
                                                  input logic [31:0] n,
                                                  input logic [31:0] l_k,
                                                  input logic [31:0] x);
        logic [31:0] dim;
        logic [31:0] lat;
        dim = 32'd3 + (n << 1);
        case (stage)
            STAGE_PRD:   lat = x * dim + 32'd8;
            STAGE_NEW:   lat = x * (32'd3 + (l_k << 1)) + 32'd8;
            STAGE_UPD:   lat = ((x * dim) << 1) + 32'd16;
            STAGE_ASSOC: lat = 32'd6 * n + 32'd8;
            default:     lat = 32'd0;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/ekf_stage_seq.sv
// Stage sequencer: accepts a command in IDLE, counts the stage latency down in
// BUSY, and raises the completed stage code for one cycle in DONE.
//
//   state  | meaning
//   S_IDLE | waiting for a valid stage command
//   S_BUSY | latency counter running down to zero
//   S_DONE | one-cycle completion pulse on stage_rdy_o
module ekf_stage_seq
    import ekf_pkg::*;
#(
    parameter int LAT_W = 18
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic [2:0]       stage_val_i,
    input  logic [LAT_W-1:0] lat_i,
    output logic             accept_o,
    output logic [2:0]       stage_rdy_o
);

    seq_state_e       state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       code_q, code_d;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            code_q  <= STAGE_IDLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        code_d      = code_q;
        accept_o    = 1'b0;
        stage_rdy_o = STAGE_IDLE;
        case (state_q)
            S_IDLE: begin
                if (is_stage_cmd(stage_val_i)) begin
                    accept_o = 1'b1;
                    code_d   = stage_val_i;
                    // Terminal count at zero lands DONE exactly lat_i edges after acceptance
                    cnt_d    = lat_i - LAT_W'(1);
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            S_DONE: begin
                stage_rdy_o = code_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: rtl/ekf_stage_ctrl.sv
// EKF-SLAM stage controller top: computes the stage latency, latches the stage
// operands on acceptance and hands sequencing to ekf_stage_seq.
module ekf_stage_ctrl
    import ekf_pkg::*;
#(
    parameter int RSA_DW  = 32,
    parameter int RSA_AW  = 17,
    parameter int ROW_LEN = 10,
    parameter int X       = 4
) (
    input  logic               clk,
    input  logic               sys_rst_n,
    input  logic [2:0]         stage_val,
    input  logic [ROW_LEN-1:0] landmark_num,
    input  logic [ROW_LEN-1:0] l_k,
    input  logic [RSA_DW-1:0]  vlr,
    input  logic [RSA_AW-1:0]  alpha,
    input  logic [RSA_DW-1:0]  rk,
    input  logic [RSA_AW-1:0]  phi,
    output logic [2:0]         stage_rdy
);

    // Wide enough for 2*X*(3+2*N)+16 at the largest N without wrapping
    localparam int LAT_W = ROW_LEN + 6 + $clog2(X);

    logic               accept;
    logic [31:0]        lat_full;
    logic [ROW_LEN-1:0] n_q, lk_q;
    logic [RSA_DW-1:0]  vlr_q, rk_q;
    logic [RSA_AW-1:0]  alpha_q, phi_q;
    logic               unused_dp;

    assign lat_full = stage_latency(stage_val, 32'(landmark_num), 32'(l_k), 32'(X));

    always_ff @(posedge clk) begin
        if (sys_rst_n) begin
            n_q     <= '0;
            lk_q    <= '0;
            vlr_q   <= '0;
            alpha_q <= '0;
            rk_q    <= '0;
            phi_q   <= '0;
        end else if (accept) begin
            n_q     <= landmark_num;
            lk_q    <= l_k;
            vlr_q   <= vlr;
            alpha_q <= alpha;
            rk_q    <= rk;
            phi_q   <= phi;
        end
    end

    // Latched operands feed the systolic datapath, which lives outside this block
    assign unused_dp = ^{n_q, lk_q, vlr_q, alpha_q, rk_q, phi_q, lat_full[31:LAT_W]};

    ekf_stage_seq #(
        .LAT_W(LAT_W)
    ) u_seq (
        .clk        (clk),
        .rst_i      (sys_rst_n),
        .stage_val_i(stage_val),
        .lat_i      (lat_full[LAT_W-1:0]),
        .accept_o   (accept),
        .stage_rdy_o(stage_rdy)
    );

endmodule

// File: tb/tb_ekf_stage_ctrl.sv
// Directed bench for ekf_stage_ctrl: table-driven stage latencies plus reset
// abort and command-during-busy sequences.
module tb_ekf_stage_ctrl;

    logic        clk;
    logic        sys_rst_n;
    logic [2:0]  stage_val;
    logic [9:0]  landmark_num;
    logic [9:0]  l_k;
    logic [31:0] vlr;
    logic [16:0] alpha;
    logic [31:0] rk;
    logic [16:0] phi;
    logic [2:0]  stage_rdy;

    int checks = 0;
    int errors = 0;

    ekf_stage_ctrl dut (
        .clk         (clk),
        .sys_rst_n   (sys_rst_n),
        .stage_val   (stage_val),
        .landmark_num(landmark_num),
        .l_k         (l_k),
        .vlr         (vlr),
        .alpha       (alpha),
        .rk          (rk),
        .phi         (phi),
        .stage_rdy   (stage_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] code;
        logic [9:0] n;
        logic [9:0] lk;
        int         hold;
        int         exp_lat;   // -1: no pulse expected
        logic [2:0] exp_code;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic randomize_operands();
        vlr   = $urandom();
        alpha = 17'($urandom());
        rk    = $urandom();
        phi   = 17'($urandom());
    endtask

    // Edge 0 is the accepting edge; the pulse is expected on edge exp_lat.
    task automatic run_stage(input string nm, input logic [2:0] code,
                             input logic [9:0] n, input logic [9:0] lk,
                             input int hold, input int exp_lat,
                             input logic [2:0] exp_code, input int window,
                             input int inj_edge, input logic [2:0] inj_code);
        int         first;
        int         cnt;
        logic [2:0] got;
        first = -1;
        cnt   = 0;
        got   = 3'b000;
        landmark_num = n;
        l_k          = lk;
        stage_val    = code;
        randomize_operands();
        for (int e = 0; e <= window; e++) begin
            if (e == hold) stage_val = 3'b000;
            if (e == inj_edge) begin
                stage_val    = inj_code;
                landmark_num = 10'd0;
                l_k          = 10'd0;
                randomize_operands();
            end
            if (inj_edge >= 0 && e == inj_edge + 1) stage_val = 3'b000;
            step();
            if (stage_rdy != 3'b000) begin
                cnt++;
                if (first < 0) begin
                    first = e;
                    got   = stage_rdy;
                end
            end
        end
        stage_val = 3'b000;
        if (exp_lat < 0) begin
            chk({nm, "_no_pulse"}, cnt, 0);
        end else begin
            chk({nm, "_latency"}, first, exp_lat);
            chk({nm, "_code"}, int'(got), int'(exp_code));
            chk({nm, "_pulse_count"}, cnt, 1);
        end
    endtask

    initial begin
        int pulses;

        sys_rst_n    = 1'b1;
        stage_val    = 3'b000;
        landmark_num = 10'd0;
        l_k          = 10'd0;
        vlr          = '0;
        alpha        = '0;
        rk           = '0;
        phi          = '0;

        for (int i = 0; i < 2; i++) begin
            step();
            chk("reset_rdy", int'(stage_rdy), 0);
        end
        sys_rst_n = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (stage_rdy != 3'b000) pulses++;
        end
        chk("idle_quiet", pulses, 0);

        vecs.push_back('{3'b011, 10'd4,    10'd0,    2, 104,   3'b011});
        vecs.push_back('{3'b001, 10'd4,    10'd0,    1, 52,    3'b001});
        vecs.push_back('{3'b010, 10'd4,    10'd2,    1, 36,    3'b010});
        vecs.push_back('{3'b100, 10'd4,    10'd0,    1, 32,    3'b100});
        vecs.push_back('{3'b110, 10'd4,    10'd0,    3, -1,    3'b000});
        vecs.push_back('{3'b111, 10'd4,    10'd0,    3, -1,    3'b000});
        vecs.push_back('{3'b101, 10'd4,    10'd0,    3, -1,    3'b000});
        vecs.push_back('{3'b001, 10'd0,    10'd0,    1, 20,    3'b001});
        vecs.push_back('{3'b011, 10'd0,    10'd0,    1, 40,    3'b011});
        vecs.push_back('{3'b100, 10'd0,    10'd0,    1, 8,     3'b100});
        vecs.push_back('{3'b010, 10'd0,    10'd0,    1, 20,    3'b010});
        vecs.push_back('{3'b010, 10'd5,    10'd1023, 1, 8204,  3'b010});
        vecs.push_back('{3'b011, 10'd1023, 10'd0,    1, 16408, 3'b011});
        vecs.push_back('{3'b100, 10'd1023, 10'd0,    1, 6146,  3'b100});
        vecs.push_back('{3'b001, 10'd1023, 10'd0,    1, 8204,  3'b001});

        foreach (vecs[i]) begin
            run_stage($sformatf("vec%0d", i), vecs[i].code, vecs[i].n, vecs[i].lk,
                      vecs[i].hold,
                      vecs[i].exp_lat,
                      vecs[i].exp_code,
                      (vecs[i].exp_lat < 0) ? 30 : vecs[i].exp_lat + 4,
                      -1, 3'b000);
        end

        // UPD aborted by reset 50 edges in: no pulse, then a clean PRD
        run_stage("abort_pre", 3'b011, 10'd4, 10'd0, 1, -1, 3'b000, 49, -1, 3'b000);
        sys_rst_n = 1'b1;
        step();
        chk("abort_reset_rdy", int'(stage_rdy), 0);
        sys_rst_n = 1'b0;
        pulses = 0;
        for (int i = 0; i < 120; i++) begin
            step();
            if (stage_rdy != 3'b000) pulses++;
        end
        chk("abort_no_pulse", pulses, 0);
        run_stage("post_abort_prd", 3'b001, 10'd4, 10'd0, 1, 52, 3'b001, 56, -1, 3'b000);

        // UPD request with N=0 during a PRD: dropped, PRD timing unchanged
        run_stage("busy_cmd", 3'b001, 10'd4, 10'd0, 1, 52, 3'b001, 52 + 110, 10, 3'b011);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
